// File: rtl/wildcube_pkg.sv
// Shared definitions for the Wild Cube display path: vertical-line motion
// state encoding and the playfield Y limits used by the coordinate counter.
package wildcube_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    IDLE    = 2'd1,
    MOVE_UP = 2'd2,
    MOVE_DN = 2'd3
  } vmove_state_t;

  // Playfield limits; the coordinate counter raises at_bot / at_top here.
  localparam int unsigned VLINE_Y_MIN = 18;
  localparam int unsigned VLINE_Y_MAX = 487;

  // True while the line is travelling in either direction.
  function automatic logic is_moving(input vmove_state_t s);
    return (s == MOVE_UP) || (s == MOVE_DN);
  endfunction

endpackage

// File: rtl/frame_prescaler.sv
// Frame-tick prescaler: counts frame pulses modulo DIV while enabled and
// flags the frame on which the count wraps, i.e. the step-decision frame.
module frame_prescaler #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic frame,
  output logic step
);

  localparam logic [3:0] LAST = 4'(DIV - 1);

  logic [3:0] r_cnt;

  // Advance on each enabled frame, wrapping to 0 after DIV-1.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= 4'd0;
    end else if (en && frame) begin
      r_cnt <= (r_cnt == LAST) ? 4'd0 : r_cnt + 4'd1;
    end
  end

  assign step = en && frame && (r_cnt == LAST);

endmodule

// File: rtl/vline_motion_ctrl.sv
// Vertical-line motion controller: paces UP/DW strobes to the frame tick,
// issues LD after reset or on reload, and handles the playfield limits.
// Build option: define VLINE_BOUNCE_EN to reverse direction at a limit
// instead of stopping in IDLE.
module vline_motion_ctrl
  import wildcube_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic frame,
  input  logic start,
  input  logic stop,
  input  logic dir_sel,
  input  logic reload,
  input  logic at_top,
  input  logic at_bot,
  output logic UP,
  output logic DW,
  output logic LD,
  output logic moving,
  output logic dir,
  output logic limit
);

  vmove_state_t r_state;
  logic         r_up;
  logic         r_dw;
  logic         r_ld;
  logic         r_moving;
  logic         r_dir;
  logic         r_limit;

  logic         w_clr;
  logic         w_en;
  logic         w_step;

  // A fresh start always begins a full DIV-frame step period.
  assign w_clr = (r_state == IDLE) && start && !reload;
  assign w_en  = is_moving(r_state);

  frame_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_en),
    .frame (frame),
    .step  (w_step)
  );

  // Motion FSM with registered strobes; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= LOAD;
      r_up     <= 1'b0;
      r_dw     <= 1'b0;
      r_ld     <= 1'b0;
      r_moving <= 1'b0;
      r_dir    <= 1'b0;
      r_limit  <= 1'b0;
    end else begin
      r_up    <= 1'b0;
      r_dw    <= 1'b0;
      r_ld    <= 1'b0;
      r_limit <= 1'b0;
      case (r_state)
        LOAD: begin
          r_ld     <= 1'b1;
          r_moving <= 1'b0;
          r_state  <= IDLE;
        end
        IDLE: begin
          if (reload) begin
            r_state <= LOAD;
          end else if (start) begin
            r_state  <= dir_sel ? MOVE_UP : MOVE_DN;
            r_dir    <= dir_sel;
            r_moving <= 1'b1;
          end
        end
        MOVE_UP: begin
          if (stop) begin
            r_state  <= IDLE;
            r_moving <= 1'b0;
          end else if (w_step) begin
            if (!at_top) begin
              r_up <= 1'b1;
            end else begin
              r_limit <= 1'b1;
`ifdef VLINE_BOUNCE_EN
              r_state <= MOVE_DN;
              r_dir   <= 1'b0;
`else
              r_state  <= IDLE;
              r_moving <= 1'b0;
`endif
            end
          end
        end
        MOVE_DN: begin
          if (stop) begin
            r_state  <= IDLE;
            r_moving <= 1'b0;
          end else if (w_step) begin
            if (!at_bot) begin
              r_dw <= 1'b1;
            end else begin
              r_limit <= 1'b1;
`ifdef VLINE_BOUNCE_EN
              r_state <= MOVE_UP;
              r_dir   <= 1'b1;
`else
              r_state  <= IDLE;
              r_moving <= 1'b0;
`endif
            end
          end
        end
        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

  assign UP     = r_up;
  assign DW     = r_dw;
  assign LD     = r_ld;
  assign moving = r_moving;
  assign dir    = r_dir;
  assign limit  = r_limit;

endmodule

// File: tb/tb_vline_motion_ctrl.sv
// Bench for vline_motion_ctrl: directed scenarios followed by random traffic,
// each cycle compared against a behavioural model that also stands in for
// the coordinate counter driving at_top / at_bot.
module tb_vline_motion_ctrl;

  localparam int DIV   = 2;
  localparam int Y_BOT = 18;
  localparam int Y_TOP = 487;

  logic clk = 1'b0;
  logic reset, frame, start, stop, dir_sel, reload, at_top, at_bot;
  logic UP, DW, LD, moving, dir, limit;

  always #5 clk = ~clk;

  vline_motion_ctrl #(.DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .frame   (frame),
    .start   (start),
    .stop    (stop),
    .dir_sel (dir_sel),
    .reload  (reload),
    .at_top  (at_top),
    .at_bot  (at_bot),
    .UP      (UP),
    .DW      (DW),
    .LD      (LD),
    .moving  (moving),
    .dir     (dir),
    .limit   (limit)
  );

  int n_vec = 0;
  int n_err = 0;

  // Counter stand-in and load value (-1 selects a random switch setting).
  int y        = 100;
  int sw_force = -1;
  int gap      = 10;

  // Behavioural model: move is +1 / -1 / 0, frames counted since start.
  bit m_ldpend = 1'b0;
  int m_move   = 0;
  bit m_dir    = 1'b0;
  int m_frames = 0;
  bit e_up = 0, e_dw = 0, e_ld = 0, e_lim = 0, e_mov = 0, e_dir = 0;

  task automatic chk(input string tag, input logic obs, input bit exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b, expected %b", tag, $time, obs, exp);
    end
  endtask

  function automatic int pick_sw();
    case ($urandom_range(0, 3))
      0:       return Y_BOT + int'($urandom_range(0, 3));
      1:       return Y_TOP - int'($urandom_range(0, 3));
      default: return int'($urandom_range(Y_BOT, Y_TOP));
    endcase
  endfunction

  // One clock: drive inputs, predict outputs, advance counter, compare.
  task automatic cycle(input bit rs, input bit fr, input bit st,
                       input bit sp, input bit ds, input bit rl);
    bit c_up, c_dw, c_ld;
    reset   = rs;
    frame   = fr;
    start   = st;
    stop    = sp;
    dir_sel = ds;
    reload  = rl;
    at_top  = (y == Y_TOP);
    at_bot  = (y == Y_BOT);
    gap     = fr ? 0 : gap + 1;

    c_up = e_up;
    c_dw = e_dw;
    c_ld = e_ld;
    e_up = 0; e_dw = 0; e_ld = 0; e_lim = 0;

    if (rs) begin
      m_ldpend = 1; m_move = 0; m_dir = 0; m_frames = 0;
    end else if (m_ldpend) begin
      e_ld = 1; m_ldpend = 0;
    end else if (m_move == 0) begin
      if (rl) m_ldpend = 1;
      else if (st) begin
        m_move = ds ? 1 : -1; m_dir = ds; m_frames = 0;
      end
    end else if (sp) begin
      m_move = 0;
    end else if (fr) begin
      m_frames++;
      if (m_frames % DIV == 0) begin
        if ((m_move > 0 && y == Y_TOP) || (m_move < 0 && y == Y_BOT)) begin
          e_lim = 1;
`ifdef VLINE_BOUNCE_EN
          m_move = -m_move;
          m_dir  = ~m_dir;
`else
          m_move = 0;
`endif
        end else if (m_move > 0) e_up = 1;
        else e_dw = 1;
      end
    end
    e_mov = (m_move != 0);
    e_dir = m_dir;

    if (c_up) y++;
    if (c_dw) y--;
    if (c_ld) y = (sw_force >= 0) ? sw_force : pick_sw();

    @(posedge clk);
    @(negedge clk);
    chk("UP", UP, e_up);
    chk("DW", DW, e_dw);
    chk("LD", LD, e_ld);
    chk("limit", limit, e_lim);
    chk("moving", moving, e_mov);
    chk("dir", dir, e_dir);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  // Frame pulses spaced so counter flags settle between steps.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 1, 0, 0, 0, 0);
      idle(3);
    end
  endtask

  task automatic load_at(input int v);
    sw_force = v;
    cycle(0, 0, 0, 0, 0, 1);
    idle(3);
  endtask

  initial begin
    // Reset and release: single LD pulse.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 1, 0);
    sw_force = 200;
    idle(4);

    // Upward motion mid-field: UP after frames 2, 4, 6.
    cycle(0, 0, 1, 0, 1, 0);
    idle(2);
    frames(6);
    cycle(0, 0, 0, 1, 0, 0);
    idle(2);

    // Approach and hit the top limit.
    load_at(485);
    cycle(0, 0, 1, 0, 1, 0);
    frames(12);
    cycle(0, 0, 0, 1, 0, 0);
    idle(2);

    // Downward motion; stop on a step-decision frame.
    load_at(300);
    cycle(0, 0, 1, 0, 0, 0);
    idle(2);
    frames(1);
    cycle(0, 1, 0, 1, 0, 0);
    idle(3);
    frames(4);

    // Reload together with start, then reload while moving down.
    cycle(0, 0, 1, 0, 1, 1);
    idle(4);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    frames(4);
    cycle(0, 0, 0, 1, 0, 0);
    idle(2);

    // Bottom limit.
    load_at(20);
    cycle(0, 0, 1, 0, 0, 0);
    frames(10);
    cycle(0, 0, 0, 1, 0, 0);
    idle(2);

    // Reset lands on the step-decision cycle of a pending UP.
    load_at(250);
    cycle(0, 0, 1, 0, 1, 0);
    idle(2);
    frames(1);
    cycle(1, 1, 0, 0, 0, 0);
    idle(5);

    // Random traffic.
    sw_force = -1;
    for (int i = 0; i < 4000; i++) begin
      bit rs, fr, st, sp, ds, rl;
      rs = ($urandom_range(0, 599) == 0);
      fr = (gap >= 3) && ($urandom_range(0, 1) == 1);
      st = ($urandom_range(0, 19) == 0);
      sp = ($urandom_range(0, 69) == 0);
      ds = $urandom_range(0, 1);
      rl = ($urandom_range(0, 39) == 0);
      cycle(rs, fr, st, sp, ds, rl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vline_motion_ctrl.md
# vline_motion_ctrl

Motion controller that drives the up/down/load strobes of the vertical-line coordinate counter in the Wild Cube display path. It paces movement to the VGA frame tick and reads the counter's top/bottom terminal flags back. It then either reverses direction or stops at the playfield limits (Y = 18 bottom, Y = 487 top). It is the initiator side of the counter's UP/DW/LD strobe interface.

## Interface
- `DIV`, default 2: frame ticks per one-pixel step; legal range 1..15.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high; one clock; all state is cleared on the clk edge where reset=1.
- `frame` input 1: one-cycle pulse, once per video frame.
- `start` input 1: one-cycle pulse; begins motion from IDLE.
- `stop` input 1: one-cycle pulse; returns to IDLE from any MOVE state.
- `dir_sel` input 1: initial direction sampled on `start` (1 = up/increment, 0 = down).
- `reload` input 1: one-cycle pulse; requests a coordinate load; honoured in IDLE only.
- `at_top` input 1: counter terminal flag, coordinate = 487.
- `at_bot` input 1: counter terminal flag, coordinate = 18.
- `UP` output 1: one-cycle increment strobe to the counter.
- `DW` output 1: one-cycle decrement strobe.
- `LD` output 1: one-cycle load strobe; the counter loads from switches.
- `moving` output 1: high in MOVE_UP or MOVE_DN.
- `dir` output 1: current direction (1 = up).
- `limit` output 1: one-cycle pulse when a limit is reached.

## Operation
- States: LOAD, IDLE, MOVE_UP, MOVE_DN.
- Reset: state = LOAD, prescaler = 0, dir = 0.
  - All outputs are 0 while reset is held.
- LOAD: LD = 1 for exactly one cycle, then go to IDLE.
- IDLE:
  - `reload` goes to LOAD.
  - `start` goes to MOVE_UP if dir_sel = 1, else MOVE_DN; the prescaler is cleared and dir is set from dir_sel.
  - If `start` and `reload` arrive together, reload wins.
- MOVE states:
  - Each `frame` increments the prescaler.
  - When the prescaler equals DIV-1 on a `frame` cycle, it wraps to 0 and a step decision is made in that cycle.
- Step decision in MOVE_UP:
  - If at_top = 0: assert UP next cycle.
  - If at_top = 1: no strobe, `limit` pulses, and the limit action applies (see Configuration).
- Step decision in MOVE_DN: the mirror of MOVE_UP, using at_bot and DW.
- `stop` in a MOVE state goes to IDLE next cycle and no further strobes are issued.
  - If `stop` coincides with a step decision, stop wins and no strobe is issued.
- `reload` and `start` are ignored in MOVE states.
- UP and DW are never high in the same cycle. LD is never high together with UP or DW.
- The controller never strobes the counter past 18 or 487.

## Timing
- All outputs are registered.
- A strobe is high for exactly the one cycle after the frame cycle that triggered the step decision.
- at_top and at_bot are sampled in the step-decision cycle.
  - Steps are at least one frame apart, so the flags from the previous step have always settled.
- Step rate is one pixel per DIV frames. With DIV = 1, every frame produces a step.
- `moving` and `dir` update one cycle after the triggering input.
- Reset asserted mid-motion cancels any pending strobe. The controller restarts in LOAD after reset is released.

## Configuration
- Macro `VLINE_BOUNCE_EN`.
  - Defined: at a limit, the FSM flips to the opposite MOVE state and dir toggles. The first opposite-direction strobe is issued DIV frames later, so the line dwells one step period at the edge.
  - Undefined: at a limit, the FSM goes to IDLE, `moving` drops, and dir holds its value.
- `limit` pulses in both builds.

## Structure
- A shared package `wildcube_pkg` holds:
  - the state enum `vmove_state_t`;
  - constants `VLINE_Y_MIN = 18` and `VLINE_Y_MAX = 487`, which are also used by the coordinate counter's flag decode.
- One sub-module, `frame_prescaler`: a 4-bit modulo-DIV counter clocked by `frame`, with a clear input and a one-cycle `step` output.
- The FSM and output registers live in the top module.

## Test plan
- Reset release -> LD = 1 for exactly one cycle; UP = DW = 0; state IDLE; moving = 0.
- DIV = 2; start with dir_sel = 1; 6 frames with at_top = 0 -> exactly 3 UP pulses, each 1 cycle wide, on the cycle after frames 2, 4 and 6; DW never high.
- MOVE_UP; at_top = 1 at a step decision:
  - bounce build -> no UP, limit pulse, dir = 0, first DW 2 frames later;
  - non-bounce build -> limit pulse, IDLE, moving = 0.
- MOVE_DN; stop coincident with a step-decision frame -> no DW, IDLE next cycle; following frames produce no strobes.
- IDLE; reload and start in the same cycle -> LD pulse, state stays non-moving; reload issued in MOVE_DN -> no LD.
- Reset asserted in the cycle before a pending UP -> UP stays 0, then an LD pulse after reset is released.
